// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner
// Time-multiplexes one hex-to-seven-segment decoder across NUM_DIGITS
// common-anode digits. Each digit slot opens with a short all-off gap so the
// previous digit's segments never flash on the next anode (ghosting).
// The display value is double-buffered and only swapped at frame boundaries,
// so a frame never shows a mix of old and new digits.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_BLANK | slot counter < BLANK_CYCLES, all anodes off, segments/dp off
// ST_SHOW  | slot counter >= BLANK_CYCLES, current digit's anode driven
module seven_segment_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                    i_clock,
  input  logic                    i_reset_n,
  input  logic [4*NUM_DIGITS-1:0] i_value,
  input  logic                    i_load,
  input  logic                    i_lz_blank,
  input  logic [NUM_DIGITS-1:0]   i_dp_mask,
  output logic                    o_pending_full,
  output logic                    o_frame_start,
  output logic [NUM_DIGITS-1:0]   o_anode,
  output logic [6:0]              o_segments,
  output logic                    o_dp
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST       = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST       = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        w_cnt_next;
  logic [IDX_W-1:0]        r_idx;
  logic [IDX_W-1:0]        w_idx_next;
  logic                    w_slot_end;
  logic                    w_frame_boundary;

  logic [4*NUM_DIGITS-1:0] r_active;
  logic [4*NUM_DIGITS-1:0] r_pending;

  logic [NUM_DIGITS-1:0]   w_lz_mask;
  logic [3:0]              w_nibble;
  logic [NUM_DIGITS-1:0]   w_anode_next;
  logic [6:0]              w_seg_next;
  logic                    w_dp_next;

  // Active-low {g,f,e,d,c,b,a} hex glyphs.
  function automatic logic [6:0] f_decode(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  // Slot counter and digit index sequencing.
  always_comb begin
    w_slot_end       = (r_cnt == CNT_LAST);
    w_frame_boundary = w_slot_end && (r_idx == IDX_LAST);
    w_cnt_next       = w_slot_end ? '0 : r_cnt + 1'b1;
    w_idx_next       = r_idx;
    if (w_slot_end) begin
      w_idx_next = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end
  end

  // Counter and index registers.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else begin
      r_cnt <= w_cnt_next;
      r_idx <= w_idx_next;
    end
  end

  // FSM state register.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_BLANK;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state: blank gap, then show until the slot wraps.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_BLANK: if (r_cnt == CNT_BLANK_LAST) w_state_next = ST_SHOW;
      ST_SHOW:  if (w_slot_end)              w_state_next = ST_BLANK;
      default:                               w_state_next = ST_BLANK;
    endcase
  end

  // Double buffer: pending collects loads, active swaps only at frame boundary.
  // A load landing exactly on the boundary bypasses pending so it is not
  // delayed by a whole frame.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_active       <= '0;
      r_pending      <= '0;
      o_pending_full <= 1'b0;
    end else if (w_frame_boundary) begin
      if (i_load) begin
        r_active       <= i_value;
        o_pending_full <= 1'b0;
      end else if (o_pending_full) begin
        r_active       <= r_pending;
        o_pending_full <= 1'b0;
      end
    end else if (i_load) begin
      r_pending      <= i_value;
      o_pending_full <= 1'b1;
    end
  end

  // Leading-zero mask: digit i is blankable if it and every digit above it are zero.
  always_comb begin : lz_scan
    logic v_upper_zero;
    w_lz_mask    = '0;
    v_upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      v_upper_zero = v_upper_zero && (r_active[4*i +: 4] == 4'h0);
      w_lz_mask[i] = v_upper_zero;
    end
  end

  // Next display outputs, computed from the next state/index so the pins
  // change on the same edge as the scan position.
  always_comb begin
    w_nibble     = r_active[4*w_idx_next +: 4];
    w_anode_next = '1;
    w_seg_next   = 7'h7F;
    w_dp_next    = 1'b1;
    if (w_state_next == ST_SHOW) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (w_idx_next == IDX_W'(i)) w_anode_next[i] = 1'b0;
      end
      w_seg_next = (i_lz_blank && w_lz_mask[w_idx_next]) ? 7'h7F : f_decode(w_nibble);
      w_dp_next  = ~i_dp_mask[w_idx_next];
    end
  end

  // Registered display pins and frame-start pulse.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_anode       <= '1;
      o_segments    <= 7'h7F;
      o_dp          <= 1'b1;
      o_frame_start <= 1'b0;
    end else begin
      o_anode       <= w_anode_next;
      o_segments    <= w_seg_next;
      o_dp          <= w_dp_next;
      o_frame_start <= w_frame_boundary;
    end
  end

endmodule
